// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: memory-controller read channel, instruction-queue output and ROB redirect.
// master = fetch unit, slave = memory controller / instruction queue / ROB side.
interface inst_fetch_if;
  logic        iq_full;
  logic        flush_en;
  logic [31:0] flush_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  iq_full, flush_en, flush_pc, mem_done, mem_inst,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output iq_full, flush_en, flush_pc, mem_done, mem_inst,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch with optional direct-mapped one-word-line icache (ICACHE_EN); hit emits next cycle,
// miss holds mem_req until mem_done then bypasses; iq_full stalls RUN and drops a fill's emit; rdy=0 freezes all.
module inst_fetch #(
  parameter int          IDX_W    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  inst_fetch_if.master bus
);
  typedef enum logic {RUN, MISS} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] miss_addr;
  logic        stale;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;

  logic        hit;
  logic [31:0] hit_data;
  logic        fill_emit;

  assign fill_emit = !stale && !bus.flush_en && !bus.iq_full;

`ifdef ICACHE_EN
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] fill_idx;
  logic             fill;

  assign idx      = pc[IDX_W+1:2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == pc[31:IDX_W+2]);
  assign hit_data = data_q[idx];
  // A fill completes even when the response is stale; flush never invalidates lines.
  assign fill     = rdy && (state == MISS) && bus.mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_q[fill_idx]  <= miss_addr[31:IDX_W+2];
      data_q[fill_idx] <= bus.mem_inst;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (IDX_W != 0);
  assign hit        = 1'b0;
  assign hit_data   = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      miss_addr    <= '0;
      stale        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else if (rdy) begin
      inst_valid_q <= 1'b0;
      case (state)
        RUN: begin
          if (bus.flush_en) begin
            pc <= bus.flush_pc;
          end else if (bus.iq_full) begin
            pc <= pc;
          end else if (hit) begin
            inst_valid_q <= 1'b1;
            inst_q       <= hit_data;
            inst_pc_q    <= pc;
            pc           <= pc + 32'd4;
          end else begin
            miss_addr  <= pc;
            stale      <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc;
            state      <= MISS;
          end
        end
        MISS: begin
          // The read in flight is always allowed to finish; a redirect only marks it stale.
          if (bus.flush_en) begin
            pc    <= bus.flush_pc;
            stale <= 1'b1;
          end
          if (bus.mem_done) begin
            mem_req_q <= 1'b0;
            state     <= RUN;
            if (fill_emit) begin
              inst_valid_q <= 1'b1;
              inst_q       <= bus.mem_inst;
              inst_pc_q    <= miss_addr;
              pc           <= miss_addr + 32'd4;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit with a direct-mapped instruction cache. It sits between the memory controller and the instruction queue. It holds the PC, looks up each PC in the cache, and on a miss issues a 4-byte instruction read to the memory controller. Fetched instructions are delivered with their PC to the instruction queue. The ROB flush port redirects it.

## Interface
- IDX_W, 8, cache index width; 2^IDX_W one-word lines
- RESET_PC, 32'h0, PC loaded on reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes every register
- iq_full  in  1  instruction queue cannot accept an entry this cycle
- flush_en  in  1  redirect request (mispredict/exception)
- flush_pc  in  32  redirect target
- mem_req  out  1  instruction read request; level, held until mem_done
- mem_addr  out  32  read address, stable while mem_req=1
- mem_done  in  1  one-cycle pulse; read complete; only asserted while rdy=1
- mem_inst  in  32  instruction word, valid in the mem_done cycle
- inst_valid  out  1  one-cycle pulse: inst/inst_pc are valid
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst

## Operation
- Registers: pc, miss_addr, stale flag, state ∈ {RUN, MISS}, valid[2^IDX_W], tag[2^IDX_W] (32-IDX_W-2 bits), data[2^IDX_W].
- Index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. hit = valid[idx] && tag[idx]==pc tag.
- All outputs are registered. Reset values: inst_valid=0, inst=0, inst_pc=0, mem_req=0, mem_addr=0, pc=RESET_PC, state=RUN, all valid=0, stale=0.
- The block updates only when rdy=1. When rdy=0, all state and outputs hold.
- RUN, priority order:
  - flush_en: pc←flush_pc, no emit.
  - iq_full: hold.
  - hit: emit {data[idx], pc}, pc←pc+4.
  - miss: miss_addr←pc, stale←0, mem_req←1, mem_addr←pc, state←MISS.
- MISS:
  - flush_en: pc←flush_pc, stale←1. The outstanding read is never aborted.
  - mem_done: fill line of miss_addr with mem_inst, mem_req←0, state←RUN.
    - Also emit {mem_inst, miss_addr} and set pc←miss_addr+4 when stale=0 && !flush_en && !iq_full.
    - Otherwise emit nothing, and pc is unchanged unless this cycle's flush sets it.
  - flush_en together with mem_done: fill still happens, no emit, pc←flush_pc.
- PC arithmetic is 32-bit and wraps mod 2^32. The low two bits of PC are carried but never used for indexing.
- Flush never invalidates the cache. There is no coherence with stores.

## Timing
- Hit: emit in the cycle after PC presentation, giving 1 instruction per cycle on consecutive hits.
- Miss:
  - mem_req rises 1 cycle after the miss is detected.
  - inst_valid rises 1 cycle after mem_done, when the bypass conditions hold.
  - mem_req falls 1 cycle after mem_done.
- The memory controller sees mem_req low for at least one cycle between reads.
- The flush takes effect at the next edge; inst_valid=0 in the following cycle. The first emit from flush_pc comes ≥1 cycle later on a hit.
- Reset mid-MISS: state returns to RUN and mem_req drops next cycle. The memory controller is reset by the same rst.

## Configuration
- ICACHE_EN defined: cache arrays present, behaviour as above.
- ICACHE_EN undefined:
  - No valid/tag/data arrays; hit is constant 0.
  - Every fetch takes the MISS path. mem_done data is only bypassed, never stored.
  - A dropped response (stale, flush, or iq_full) is refetched from RUN.

## Test plan
- Cold reset, RESET_PC=0, memory holds 0x00000013 at 0x0/0x4, iq_full=0 -> mem_req with mem_addr=0x0; after mem_done, inst_valid with inst=0x00000013, inst_pc=0x0; next request addr=0x4.
- Jump back to 0x0 via flush after the first fill (ICACHE_EN) -> inst_pc=0x0 emitted with no mem_req, 1 cycle after the flush takes effect; consecutive hits give inst_valid on back-to-back cycles.
- flush_en (flush_pc=0x100) mid-MISS for addr 0x8 -> mem_req/mem_addr=0x8 held until mem_done, no inst_pc=0x8 emitted, next request addr=0x100.
- iq_full=1 in the mem_done cycle for addr 0xC -> no emit. With ICACHE_EN, inst_pc=0xC is emitted from a hit after iq_full drops; without it, a second request for 0xC is issued.
- Conflicting addresses 0x0 and 0x400 (IDX_W=8) fetched alternately -> every fetch misses and inst words are correct; rdy=0 for 3 cycles mid-sequence -> all outputs frozen, no skipped PC.
